// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lockout controller.
//   lk_state_t : controller state encoding
//   KEY_HASH / KEY_STAR : operator key codes from the scanner
//   ENTRY_LEN  : keys per complete entry (4 digits + operator)
//   max2       : elaboration-time helper for sizing the shared timer
package lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_ABORT,
    ST_LOCKOUT
  } lk_state_t;

  localparam logic [3:0] KEY_HASH  = 4'b1010;
  localparam logic [3:0] KEY_STAR  = 4'b1011;
  localparam int         ENTRY_LEN = 5;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter, shared by entry timeout and lockout duration.
//   clk, rst : clock, async active-high reset (count clears to 0)
//   load     : load 'value' this cycle (wins over en)
//   value    : value to load
//   en       : count down by one while nonzero
//   zero     : count is 0
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] r_count;

  // Holds at 0 instead of wrapping, so a stale enable cannot underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_count <= '0;
    else if (load)                   r_count <= value;
    else if (en && (r_count != '0))  r_count <= r_count - 1'b1;
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/lockout_ctrl.sv
// Attempt-limiting controller between keypad scanner and code decider.
// Forwards key code / key valid with one cycle of latency, counts
// consecutive wrong entries from the decider's wrap-around counter, blocks
// the keypad with a blinking alarm after MAX_WRONG failures, and aborts a
// stalled partial entry.
//   clk, reset_1      : clock, async active-high reset
//   key_code_in/valid : scanner key code and key-valid level
//   wrong_cnt         : decider wrong-attempt counter (mod 16)
//   open_in           : decider OPEN level
//   key_code_out      : registered key code
//   key_valid_out     : registered key valid, 0 while locked out
//   entry_abort       : one-cycle pulse clearing the partial entry
//   lockout, alarm    : lockout active / blinking alarm
//   attempts_left     : MAX_WRONG - consecutive wrong count, 0 when locked
module lockout_ctrl import lock_pkg::*; #(
  parameter int MAX_WRONG      = 3,
  parameter int LOCKOUT_CYCLES = 50_000_000,
  parameter int ENTRY_TIMEOUT  = 25_000_000,
  parameter int BLINK_HALF     = 12_500_000
) (
  input  logic       clk,
  input  logic       reset_1,
  input  logic [3:0] key_code_in,
  input  logic       key_valid_in,
  input  logic [3:0] wrong_cnt,
  input  logic       open_in,
  output logic [3:0] key_code_out,
  output logic       key_valid_out,
  output logic       entry_abort,
  output logic       lockout,
  output logic       alarm,
  output logic [3:0] attempts_left
);

  localparam int TW = $clog2(max2(LOCKOUT_CYCLES, ENTRY_TIMEOUT));
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  lk_state_t      r_state, w_state_nxt;
  logic [3:0]     r_cw, w_cw_nxt, w_cw_evt;
  logic [2:0]     r_kc, w_kc_nxt;
  logic           r_kv_prev, r_open_prev, r_wrong_ev, r_open_ev;
  logic [3:0]     r_wc_prev;
  logic           w_key_ev, w_lock;
  logic           w_t_load, w_t_en, w_t_zero;
  logic [TW-1:0]  w_t_val;
  logic [3:0]     r_code;
  logic           r_kv_out, r_alarm;
  logic [BW-1:0]  r_blink;
  logic [3:0]     r_att;

  assign w_key_ev = key_valid_in & ~r_kv_prev;

  // Edge register stage. Wrong/open edges seen while locked out are
  // swallowed here so they cannot leak into IDLE after the lockout ends.
  always_ff @(posedge clk or posedge reset_1) begin
    if (reset_1) begin
      r_kv_prev   <= 1'b0;
      r_open_prev <= 1'b0;
      r_wc_prev   <= 4'd0;
      r_wrong_ev  <= 1'b0;
      r_open_ev   <= 1'b0;
    end else begin
      r_kv_prev   <= key_valid_in;
      r_open_prev <= open_in;
      r_wc_prev   <= wrong_cnt;
      r_wrong_ev  <= (wrong_cnt != r_wc_prev) && (r_state != ST_LOCKOUT);
      r_open_ev   <= open_in && !r_open_prev && (r_state != ST_LOCKOUT);
    end
  end

  // Consecutive-wrong update; open beats a coincident wrong event.
  always_comb begin
    w_cw_evt = r_cw;
    if (r_open_ev)       w_cw_evt = 4'd0;
    else if (r_wrong_ev) w_cw_evt = (r_cw == 4'd15) ? 4'd15 : r_cw + 4'd1;
  end

  assign w_lock = r_wrong_ev && !r_open_ev && (r_state != ST_LOCKOUT) &&
                  (w_cw_evt >= 4'(MAX_WRONG));

  always_comb begin
    w_state_nxt = r_state;
    w_cw_nxt    = r_cw;
    w_kc_nxt    = r_kc;
    w_t_load    = 1'b0;
    w_t_val     = '0;
    w_t_en      = 1'b0;
    if (r_state == ST_LOCKOUT) begin
      w_t_en = 1'b1;
      if (w_t_zero) begin
        w_cw_nxt    = 4'd0;
        w_state_nxt = ST_IDLE;
      end
    end else begin
      w_cw_nxt = w_cw_evt;
      if (w_lock) begin
        w_state_nxt = ST_LOCKOUT;
        w_kc_nxt    = 3'd0;
        w_t_load    = 1'b1;
        w_t_val     = TW'(LOCKOUT_CYCLES - 1);
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_key_ev) begin
              w_kc_nxt    = 3'd1;
              w_state_nxt = ST_ENTRY;
              w_t_load    = 1'b1;
              w_t_val     = TW'(ENTRY_TIMEOUT - 1);
            end
          end
          ST_ENTRY: begin
            w_t_en = 1'b1;
            // A key landing on the expiry cycle keeps the entry alive.
            if (w_key_ev) begin
              w_t_load = 1'b1;
              w_t_val  = TW'(ENTRY_TIMEOUT - 1);
              if (r_kc + 3'd1 == 3'(ENTRY_LEN)) begin
                w_kc_nxt    = 3'd0;
                w_state_nxt = ST_IDLE;
              end else begin
                w_kc_nxt = r_kc + 3'd1;
              end
            end else if (w_t_zero) begin
              w_state_nxt = ST_ABORT;
            end
          end
          ST_ABORT: begin
            w_kc_nxt    = 3'd0;
            w_state_nxt = ST_IDLE;
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset_1) begin
    if (reset_1) begin
      r_state <= ST_IDLE;
      r_cw    <= 4'd0;
      r_kc    <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cw    <= w_cw_nxt;
      r_kc    <= w_kc_nxt;
    end
  end

  lock_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (reset_1),
    .load  (w_t_load),
    .value (w_t_val),
    .en    (w_t_en),
    .zero  (w_t_zero)
  );

  // Output registers. A key arriving on the lockout-entry cycle is dropped.
  always_ff @(posedge clk or posedge reset_1) begin
    if (reset_1) begin
      r_code   <= 4'd0;
      r_kv_out <= 1'b0;
      r_att    <= 4'(MAX_WRONG);
    end else begin
      r_code   <= key_code_in;
      r_kv_out <= key_valid_in && (r_state != ST_LOCKOUT) && !w_lock;
      r_att    <= (r_state == ST_LOCKOUT) ? 4'd0 : 4'(MAX_WRONG) - r_cw;
    end
  end

  // Alarm starts high on lockout entry and flips every BLINK_HALF cycles.
  always_ff @(posedge clk or posedge reset_1) begin
    if (reset_1) begin
      r_alarm <= 1'b0;
      r_blink <= '0;
    end else if (w_lock) begin
      r_alarm <= 1'b1;
      r_blink <= '0;
    end else if ((r_state == ST_LOCKOUT) && !w_t_zero) begin
      if (r_blink == BW'(BLINK_HALF - 1)) begin
        r_blink <= '0;
        r_alarm <= ~r_alarm;
      end else begin
        r_blink <= r_blink + 1'b1;
      end
    end else begin
      r_alarm <= 1'b0;
      r_blink <= '0;
    end
  end

  assign key_code_out  = r_code;
  assign key_valid_out = r_kv_out;
  assign entry_abort   = (r_state == ST_ABORT);
  assign lockout       = (r_state == ST_LOCKOUT);
  assign alarm         = r_alarm;
  assign attempts_left = r_att;

endmodule

// File: tb/tb_lockout_ctrl.sv
module tb_lockout_ctrl;
  localparam int MW = 3, LC = 20, ET = 10, BH = 4;

  logic       clk = 1'b0, reset_1, kv, op;
  logic [3:0] kc, wc;
  logic [3:0] key_code_out, attempts_left;
  logic       key_valid_out, entry_abort, lockout, alarm;

  int n_cmp = 0, n_bad = 0;
  int m_cw;  // reference: consecutive wrong entries since last clear

  lockout_ctrl #(.MAX_WRONG(MW), .LOCKOUT_CYCLES(LC), .ENTRY_TIMEOUT(ET),
                 .BLINK_HALF(BH)) dut (
    .clk(clk), .reset_1(reset_1), .key_code_in(kc), .key_valid_in(kv),
    .wrong_cnt(wc), .open_in(op), .key_code_out(key_code_out),
    .key_valid_out(key_valid_out), .entry_abort(entry_abort),
    .lockout(lockout), .alarm(alarm), .attempts_left(attempts_left));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_1 = 1'b1; kv = 1'b0; kc = 4'd0; wc = 4'd0; op = 1'b0; m_cw = 0;
    tick(); tick();
    reset_1 = 1'b0;
    tick();
  endtask

  // One wrong entry: any nonzero delta on wrong_cnt, then let it settle.
  task automatic wrong_step();
    wc = wc + 4'($urandom_range(1, 15));
    tick(); tick(); tick();
    m_cw = m_cw + 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (key_code_out !== 4'd0) begin n_bad++; $display("FAIL rst_code: got %0d want 0", key_code_out); end
    n_cmp++; if (key_valid_out !== 1'b0) begin n_bad++; $display("FAIL rst_kv: got %b want 0", key_valid_out); end
    n_cmp++; if (entry_abort !== 1'b0) begin n_bad++; $display("FAIL rst_abort: got %b want 0", entry_abort); end
    n_cmp++; if (lockout !== 1'b0) begin n_bad++; $display("FAIL rst_lock: got %b want 0", lockout); end
    n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL rst_alarm: got %b want 0", alarm); end
    n_cmp++; if (attempts_left !== 4'(MW)) begin n_bad++; $display("FAIL rst_att: got %0d want %0d", attempts_left, MW); end
  endtask

  task automatic test_forward();
    logic [3:0] code;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      code = (i == 0) ? 4'd5 : 4'($urandom_range(0, 11));
      kc = code; kv = 1'b1;
      tick();
      n_cmp++; if (key_code_out !== code) begin n_bad++; $display("FAIL fwd_code: got %0d want %0d", key_code_out, code); end
      n_cmp++; if (key_valid_out !== 1'b1) begin n_bad++; $display("FAIL fwd_kv: got %b want 1", key_valid_out); end
      kv = 1'b0;
      tick();
      n_cmp++; if (key_valid_out !== 1'b0) begin n_bad++; $display("FAIL fwd_kv_low: got %b want 0", key_valid_out); end
    end
    n_cmp++; if (attempts_left !== 4'(MW)) begin n_bad++; $display("FAIL fwd_att: got %0d want %0d", attempts_left, MW); end
  endtask

  task automatic test_lockout();
    int   k;
    logic exp_al;
    do_reset();
    for (int s = 0; s < MW - 1; s++) begin
      wrong_step();
      n_cmp++; if (attempts_left !== 4'(MW - m_cw)) begin n_bad++; $display("FAIL lk_att: got %0d want %0d", attempts_left, MW - m_cw); end
      n_cmp++; if (lockout !== 1'b0) begin n_bad++; $display("FAIL lk_early: got %b want 0", lockout); end
    end
    wc = wc + 4'($urandom_range(1, 15));
    tick();
    n_cmp++; if (lockout !== 1'b0) begin n_bad++; $display("FAIL lk_lat1: got %b want 0", lockout); end
    tick();
    k = 0;
    while (lockout === 1'b1 && k < 100) begin
      exp_al = ((k / BH) % 2 == 0) ? 1'b1 : 1'b0;
      n_cmp++; if (alarm !== exp_al) begin n_bad++; $display("FAIL lk_alarm k=%0d: got %b want %b", k, alarm, exp_al); end
      n_cmp++; if (key_valid_out !== 1'b0) begin n_bad++; $display("FAIL lk_kv k=%0d: got %b want 0", k, key_valid_out); end
      if (k == 1) begin
        n_cmp++; if (attempts_left !== 4'd0) begin n_bad++; $display("FAIL lk_att0: got %0d want 0", attempts_left); end
      end
      kv = (k == 3 || k == 10) ? 1'b1 : 1'b0;
      if (k == 6) wc = wc + 4'd1;  // ignored while locked
      tick();
      k++;
    end
    kv = 1'b0;
    m_cw = 0;
    n_cmp++; if (k !== LC) begin n_bad++; $display("FAIL lk_len: got %0d want %0d", k, LC); end
    n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL lk_alarm_end: got %b want 0", alarm); end
    tick();
    n_cmp++; if (attempts_left !== 4'(MW)) begin n_bad++; $display("FAIL lk_att_end: got %0d want %0d", attempts_left, MW); end
    tick(); tick(); tick();
    n_cmp++; if (lockout !== 1'b0) begin n_bad++; $display("FAIL lk_relock: got %b want 0", lockout); end
    n_cmp++; if (attempts_left !== 4'(MW)) begin n_bad++; $display("FAIL lk_att_hold: got %0d want %0d", attempts_left, MW); end
  endtask

  task automatic test_open();
    do_reset();
    wrong_step(); wrong_step();
    op = 1'b1; tick(); tick(); tick(); m_cw = 0;
    n_cmp++; if (attempts_left !== 4'(MW)) begin n_bad++; $display("FAIL op_clear: got %0d want %0d", attempts_left, MW); end
    wrong_step();
    n_cmp++; if (attempts_left !== 4'(MW - m_cw)) begin n_bad++; $display("FAIL op_after: got %0d want %0d", attempts_left, MW - m_cw); end
    n_cmp++; if (lockout !== 1'b0) begin n_bad++; $display("FAIL op_nolock: got %b want 0", lockout); end
    op = 1'b0; tick();
    // open and wrong in the same cycle: open wins
    op = 1'b1; wc = wc + 4'($urandom_range(1, 15));
    tick(); tick(); tick(); m_cw = 0;
    n_cmp++; if (attempts_left !== 4'(MW)) begin n_bad++; $display("FAIL op_tie: got %0d want %0d", attempts_left, MW); end
    op = 1'b0; tick();
    wrong_step();
    n_cmp++; if (attempts_left !== 4'(MW - m_cw)) begin n_bad++; $display("FAIL op_tie_after: got %0d want %0d", attempts_left, MW - m_cw); end
    n_cmp++; if (lockout !== 1'b0) begin n_bad++; $display("FAIL op_tie_nolock: got %b want 0", lockout); end
  endtask

  task automatic test_collision();
    logic [3:0] code;
    int n;
    do_reset();
    wrong_step(); wrong_step();
    wc = wc + 4'($urandom_range(1, 15));
    tick();
    code = 4'($urandom_range(0, 11));
    kc = code; kv = 1'b1;
    tick();
    n_cmp++; if (lockout !== 1'b1) begin n_bad++; $display("FAIL col_lock: got %b want 1", lockout); end
    n_cmp++; if (key_valid_out !== 1'b0) begin n_bad++; $display("FAIL col_kv: got %b want 0", key_valid_out); end
    n_cmp++; if (key_code_out !== code) begin n_bad++; $display("FAIL col_code: got %0d want %0d", key_code_out, code); end
    kv = 1'b0;
    n = 0;
    while (lockout === 1'b1 && n < 60) begin tick(); n++; end
    n_cmp++; if (n !== LC) begin n_bad++; $display("FAIL col_len: got %0d want %0d", n, LC); end
    n_cmp++; if (key_valid_out !== 1'b0) begin n_bad++; $display("FAIL col_kv_late: got %b want 0", key_valid_out); end
  endtask

  task automatic test_timeout();
    int n, aborts, g;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      kc = 4'($urandom_range(0, 9)); kv = 1'b1; tick();
      kv = 1'b0;
      if (i == 0) tick();
    end
    // last key event was at the previous edge; abort expected ET edges later
    n = 0;
    while (entry_abort !== 1'b1 && n < 40) begin tick(); n++; end
    n_cmp++; if (n !== ET) begin n_bad++; $display("FAIL to_delay: got %0d want %0d", n, ET); end
    tick();
    n_cmp++; if (entry_abort !== 1'b0) begin n_bad++; $display("FAIL to_width: got %b want 0", entry_abort); end
    // five keys with gaps up to the timeout boundary: no abort
    aborts = 0;
    for (int i = 0; i < 5; i++) begin
      kc = 4'($urandom_range(0, 11)); kv = 1'b1; tick();
      n_cmp++; if (key_valid_out !== 1'b1) begin n_bad++; $display("FAIL to_kv%0d: got %b want 1", i, key_valid_out); end
      if (entry_abort === 1'b1) aborts++;
      kv = 1'b0;
      if (i < 4) begin
        g = (i == 2) ? ET - 1 : $urandom_range(1, ET - 1);
        for (int j = 0; j < g; j++) begin tick(); if (entry_abort === 1'b1) aborts++; end
      end
    end
    for (int j = 0; j < 3 * ET; j++) begin tick(); if (entry_abort === 1'b1) aborts++; end
    n_cmp++; if (aborts !== 0) begin n_bad++; $display("FAIL to_full_entry: got %0d aborts want 0", aborts); end
  endtask

  task automatic test_reset_mid_entry();
    int aborts;
    do_reset();
    kc = 4'd1; kv = 1'b1; tick(); kv = 1'b0; tick();
    kc = 4'd2; kv = 1'b1; tick(); kv = 1'b0;
    tick(); tick(); tick();
    #2 reset_1 = 1'b1;
    #1;
    n_cmp++; if (key_code_out !== 4'd0) begin n_bad++; $display("FAIL rme_code: got %0d want 0", key_code_out); end
    tick();
    reset_1 = 1'b0;
    aborts = 0;
    for (int j = 0; j < 3 * ET; j++) begin tick(); if (entry_abort === 1'b1) aborts++; end
    n_cmp++; if (aborts !== 0) begin n_bad++; $display("FAIL rme_abort: got %0d aborts want 0", aborts); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    wc = 4'd15; tick(); tick(); tick(); m_cw++;
    n_cmp++; if (attempts_left !== 4'(MW - m_cw)) begin n_bad++; $display("FAIL wr_15: got %0d want %0d", attempts_left, MW - m_cw); end
    wc = 4'd0; tick(); tick(); tick(); m_cw++;
    n_cmp++; if (attempts_left !== 4'(MW - m_cw)) begin n_bad++; $display("FAIL wr_wrap: got %0d want %0d", attempts_left, MW - m_cw); end
    wc = 4'd7; tick(); tick();
    n_cmp++; if (lockout !== 1'b1) begin n_bad++; $display("FAIL wr_lock: got %b want 1", lockout); end
    tick(); tick(); tick(); tick();
    wc = 4'd5;
    #2 reset_1 = 1'b1;
    #1;
    n_cmp++; if (lockout !== 1'b0) begin n_bad++; $display("FAIL wr_rst_lock: got %b want 0", lockout); end
    n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL wr_rst_alarm: got %b want 0", alarm); end
    n_cmp++; if (attempts_left !== 4'(MW)) begin n_bad++; $display("FAIL wr_rst_att: got %0d want %0d", attempts_left, MW); end
    n_cmp++; if (key_valid_out !== 1'b0) begin n_bad++; $display("FAIL wr_rst_kv: got %b want 0", key_valid_out); end
    n_cmp++; if (entry_abort !== 1'b0) begin n_bad++; $display("FAIL wr_rst_abort: got %b want 0", entry_abort); end
    tick();
    reset_1 = 1'b0; m_cw = 0;
    // wrong_cnt=5 is compared against the post-reset 0: one event
    tick(); tick(); tick(); m_cw++;
    n_cmp++; if (attempts_left !== 4'(MW - m_cw)) begin n_bad++; $display("FAIL wr_first: got %0d want %0d", attempts_left, MW - m_cw); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_lockout();
    test_open();
    test_collision();
    test_timeout();
    test_reset_mid_entry();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
